// File: rtl/mips_pkg.sv
// Shared types and constants for the programmable instruction memory.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    localparam int WORD_BITS = 32;
    localparam logic [WORD_BITS-1:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [WORD_BITS-1:0] HALT_INSTR = 32'hFFFF_FFFF;

    function automatic int lanes_of(input int nbits);
        return nbits / 8;
    endfunction

    localparam int BYTE_LANES = lanes_of(WORD_BITS);

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into words; word_valid_o is a combinational
// pulse on the byte that completes a word so the word can be written on that edge.
module word_assembler
    import mips_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int LANES = BYTE_LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [7:0]       byte_i,
    output logic             word_valid_o,
    output logic [NBITS-1:0] word_data_o
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] asm_q, asm_d;
    logic             last_lane;

    assign last_lane = (cnt_q == CNT_W'(LANES - 1));

    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        if (clear_i) begin
            cnt_d = '0;
            asm_d = '0;
        end else if (valid_i) begin
            cnt_d = last_lane ? '0 : cnt_q + 1'b1;
            asm_d[{cnt_q, 3'b000} +: 8] = byte_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

    assign word_valid_o = valid_i && !clear_i && last_lane;

    // The top lane comes straight from the incoming byte; lower lanes are already stored.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi == LANES - 1) begin : g_top
                assign word_data_o[gi*8 +: 8] = byte_i;
            end else begin : g_low
                assign word_data_o[gi*8 +: 8] = asm_q[gi*8 +: 8];
            end
        end
    endgenerate

endmodule

// File: rtl/instr_mem_prog.sv
// Run-time loadable instruction RAM for the IF stage with registered fetch.
// Optional macro INSTR_MEM_HALT_DETECT_EN: an all-ones loaded word ends the load.
module instr_mem_prog
    import mips_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int DEPTH = 64,
    localparam int ADDR_W = $clog2(DEPTH),
    parameter logic [NBITS-1:0] NOP_WORD = NBITS'(NOP_INSTR)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load_start,
    input  logic              i_load_valid,
    input  logic [7:0]        i_load_byte,
    input  logic              i_load_end,
    input  logic              i_enable,
    input  logic [NBITS-1:0]  i_PC,
    output logic [NBITS-1:0]  o_Instruction,
    output logic              o_ready,
    output logic              o_loading,
    output logic [ADDR_W:0]   o_words,
    output logic              o_overflow,
    output logic              o_misaligned
);

    state_e           state_q, state_d;
    logic [ADDR_W:0]  words_q, words_d;
    logic             ovf_q, ovf_d;
    logic [NBITS-1:0] instr_q;
    logic             mis_q;

    logic [NBITS-1:0] ram [DEPTH];

    logic             full;
    logic             byte_take;
    logic             asm_clear;
    logic             word_valid;
    logic [NBITS-1:0] word_data;
    logic             halt_hit;

    assign full      = (words_q == (ADDR_W+1)'(DEPTH));
    assign byte_take = (state_q == ST_LOAD) && i_load_valid && !i_load_start && !full;
    // A start or end pulse discards whatever partial word is being assembled.
    assign asm_clear = (state_q != ST_LOAD) || i_load_start || i_load_end;

    word_assembler #(
        .NBITS (NBITS),
        .LANES (lanes_of(NBITS))
    ) u_asm (
        .clk          (i_clk),
        .rst          (i_reset),
        .clear_i      (asm_clear),
        .valid_i      (byte_take),
        .byte_i       (i_load_byte),
        .word_valid_o (word_valid),
        .word_data_o  (word_data)
    );

`ifdef INSTR_MEM_HALT_DETECT_EN
    assign halt_hit = word_valid && (&word_data);
`else
    assign halt_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (i_load_start) begin
                    state_d = ST_LOAD;
                    words_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (i_load_start) begin
                    words_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    if (word_valid) words_d = words_q + 1'b1;
                    if (i_load_valid && full) ovf_d = 1'b1;
                    if (i_load_end || halt_hit) state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            words_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
        end
    end

    // RAM contents deliberately survive reset; o_words gates what is fetchable.
    always_ff @(posedge i_clk) begin
        if (word_valid) ram[words_q[ADDR_W-1:0]] <= word_data;
    end

    logic [ADDR_W-1:0] fetch_idx;
    logic              in_range;
    logic              loaded;

    assign fetch_idx = i_PC[ADDR_W+1:2];
    assign in_range  = (i_PC[NBITS-1:ADDR_W+2] == '0);
    assign loaded    = ({1'b0, fetch_idx} < words_q);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            instr_q <= NOP_WORD;
            mis_q   <= 1'b0;
        end else if (state_q != ST_READY) begin
            instr_q <= NOP_WORD;
        end else if (i_enable) begin
            mis_q   <= |i_PC[1:0];
            instr_q <= (in_range && loaded) ? ram[fetch_idx] : NOP_WORD;
        end
    end

    assign o_Instruction = instr_q;
    assign o_ready       = (state_q == ST_READY);
    assign o_loading     = (state_q == ST_LOAD);
    assign o_words       = words_q;
    assign o_overflow    = ovf_q;
    assign o_misaligned  = mis_q;

endmodule

// File: tb/tb_instr_mem_prog.sv
// Directed bench for instr_mem_prog (DEPTH=4); expectations follow the halt macro.
module tb_instr_mem_prog;

    localparam int NBITS = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_start, load_valid, load_end, enable;
    logic [7:0]       load_byte;
    logic [NBITS-1:0] pc;
    logic [NBITS-1:0] instr;
    logic             ready, loading, ovf, mis;
    logic [2:0]       words;

    int errors = 0;
    int checks = 0;

    instr_mem_prog #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_load_start  (load_start),
        .i_load_valid  (load_valid),
        .i_load_byte   (load_byte),
        .i_load_end    (load_end),
        .i_enable      (enable),
        .i_PC          (pc),
        .o_Instruction (instr),
        .o_ready       (ready),
        .o_loading     (loading),
        .o_words       (words),
        .o_overflow    (ovf),
        .o_misaligned  (mis)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1; tick(); load_start = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1; tick(); load_end = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1; load_byte = b; tick(); load_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
    endtask

    task automatic fetch(input logic [31:0] addr);
        pc = addr; enable = 1'b1; tick();
    endtask

    initial begin
        rst = 1'b1; load_start = 0; load_valid = 0; load_end = 0;
        load_byte = 8'h00; enable = 1'b1; pc = '0;
        tick(); tick();
        check("rst_instr", instr, 32'h0);
        check("rst_words", {29'd0, words}, 32'd0);
        check("rst_flags", {28'd0, ready, loading, ovf, mis}, 32'h0);
        rst = 1'b0;
        tick();
        fetch(0);
        check("idle_fetch", instr, 32'h0);

        // Basic load of one word
        pulse_start();
        send_byte(8'h20); send_byte(8'h38); send_byte(8'hE7); send_byte(8'h00);
        check("load_busy", {31'd0, loading}, 32'd1);
        check("load_words1", {29'd0, words}, 32'd1);
        pulse_end();
        check("load_ready", {31'd0, ready}, 32'd1);
        fetch(0);
        check("fetch_w0", instr, 32'h00E73820);

        // Stall hold
        pulse_start();
        send_word(32'h01234567); send_word(32'h89ABCDEF); send_word(32'h0F1E2D3C);
        pulse_end();
        fetch(4);
        check("stall_w1", instr, 32'h89ABCDEF);
        enable = 1'b0; pc = 8;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", instr, 32'h89ABCDEF);
        end
        enable = 1'b1;
        tick();
        check("stall_w2", instr, 32'h0F1E2D3C);

        // Unloaded, out-of-range and misaligned fetch
        pulse_start();
        send_word(32'hA5A50001); send_word(32'h5A5A0002);
        pulse_end();
        fetch(8);
        check("unloaded_nop", instr, 32'h0);
        fetch(4*DEPTH);
        check("range_nop", instr, 32'h0);
        fetch(6);
        check("misal_word", instr, 32'h5A5A0002);
        check("misal_flag", {31'd0, mis}, 32'd1);
        fetch(4);
        check("aligned_flag", {31'd0, mis}, 32'd0);

        // Overflow: 20 bytes into 4 words
        pulse_start();
        send_word(32'h10000000); send_word(32'h20000001);
        send_word(32'h30000002); send_word(32'h40000003);
        send_word(32'hDEADBEEF);
        check("ovf_words", {29'd0, words}, 32'd4);
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        check("ovf_loading", {31'd0, loading}, 32'd1);
        pulse_end();
        fetch(12);
        check("ovf_w3", instr, 32'h40000003);

        // Restart mid-word
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB);
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        pulse_end();
        check("rst_words1", {29'd0, words}, 32'd1);
        check("rst_ovf_clr", {31'd0, ovf}, 32'd0);
        fetch(0);
        check("restart_w0", instr, 32'h44332211);
        fetch(6);
        check("restart_nop", instr, 32'h0);
        check("restart_mis", {31'd0, mis}, 32'd1);

        // Asynchronous reset in the middle of a load
        pulse_start();
        send_word(32'h5555AAAA); send_byte(8'h77);
        rst = 1'b1;
        #1;
        check("arst_words", {29'd0, words}, 32'd0);
        check("arst_flags", {28'd0, ready, loading, ovf, mis}, 32'h0);
        check("arst_instr", instr, 32'h0);
        tick();
        rst = 1'b0;
        fetch(0);
        check("arst_fetch", instr, 32'h0);

        // All-ones word after one word
        pulse_start();
        send_word(32'hCAFEF00D); send_word(32'hFFFFFFFF);
        check("halt_words", {29'd0, words}, 32'd2);
`ifdef INSTR_MEM_HALT_DETECT_EN
        check("halt_ready", {31'd0, ready}, 32'd1);
`else
        check("halt_loading", {31'd0, loading}, 32'd1);
        pulse_end();
`endif
        fetch(4);
        check("halt_w1", instr, 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_prog.md
Name: instr_mem_prog

Overview:
- Programmable, parametrised instruction memory for the MIPS pipeline IF stage.
- Replaces the fixed initial-block ROM with a word-addressed RAM. The RAM is filled at run time by a byte-serial loader (fed by the debug/UART unit) and read synchronously by the fetch stage using the byte PC.
- Adds stall hold, out-of-range and misaligned handling, and load-status outputs.

Parameters:
- NBITS, 32, instruction word width; must be a multiple of 8.
- DEPTH, 64, number of instruction words; power of two.
- ADDR_W, $clog2(DEPTH), word-index width. Derived; never overridden.
- NOP_WORD, 32'h00000000, word driven when no valid fetch is possible.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_reset  in  1  reset. Asynchronous assert, active-high.
- i_load_start  in  1  one-cycle pulse: enter LOAD, clear write pointer and byte counter.
- i_load_valid  in  1  i_load_byte is valid this cycle.
- i_load_byte  in  8  program byte, little-endian within each word.
- i_load_end  in  1  one-cycle pulse: finish load (a partial word is discarded).
- i_enable  in  1  fetch enable; 0 = stall, output holds.
- i_PC  in  NBITS  byte address from the PC register.
- o_Instruction  out  NBITS  fetched instruction, registered.
- o_ready  out  1  state == READY.
- o_loading  out  1  state == LOAD.
- o_words  out  ADDR_W+1  count of complete words written in the last/current load.
- o_overflow  out  1  sticky: bytes arrived while the RAM was full.
- o_misaligned  out  1  registered: i_PC[1:0] != 0 on the last enabled fetch.

Behaviour:
- Reset (async, i_reset=1):
  - state=IDLE; o_Instruction=NOP_WORD; o_words=0; o_overflow=0; o_misaligned=0.
  - Byte counter and word assembly register are cleared.
  - RAM contents are not cleared.
- States: IDLE, LOAD, READY.
- IDLE:
  - i_load_start -> LOAD.
  - Fetch returns NOP_WORD.
- LOAD:
  - Each i_load_valid shifts the byte into the assembly register at lane byte_cnt (lane 0 = bits 7:0).
  - On the 4th byte, the complete word is written to RAM[wr_ptr] on that same edge; then wr_ptr++, o_words++, byte_cnt=0.
  - i_load_end -> READY. Any partial bytes are dropped.
  - i_load_start -> restart: wr_ptr=0, o_words=0, byte_cnt=0, o_overflow=0; stay in LOAD.
  - i_load_start and i_load_valid in the same cycle: start wins and the byte is dropped.
  - Full (o_words == DEPTH): further bytes are ignored and o_overflow is set. The block stays in LOAD until i_load_end.
  - Fetch returns NOP_WORD; the pipeline must not run during load.
- READY:
  - i_load_start -> LOAD. Other load inputs are ignored.
- Fetch (READY only), 1-cycle latency:
  - If i_enable=1, at edge N o_Instruction <= RAM[i_PC[ADDR_W+1:2]]. The value is visible in cycle N+1.
  - If i_enable=0, o_Instruction and o_misaligned hold their values.
  - Word index >= o_words: output NOP_WORD (unloaded region).
  - i_PC >= 4*DEPTH: output NOP_WORD.
  - Misaligned PC: the low two bits are ignored for the index and o_misaligned=1.
- Leaving READY forces o_Instruction=NOP_WORD on the next edge.
- Reset during LOAD: the block returns to IDLE. Words already written remain in RAM, but o_words=0 so they are never fetched.

Optional Feature:
- Macro: INSTR_MEM_HALT_DETECT_EN.
- Defined:
  - In LOAD, a completed word equal to all-ones (the HALT encoding) is written, counted, and transitions to READY on the same edge.
  - i_load_end still works as well.
- Undefined:
  - All-ones is an ordinary word.
  - Only i_load_end leaves LOAD.

Decomposition:
- Shared package mips_pkg holds:
  - state enum (IDLE/LOAD/READY)
  - NOP_WORD and HALT_WORD constants
  - byte-lane count NBITS/8
- One sub-module: word_assembler. It holds the byte counter and assembly register, and outputs word_valid and word_data.
- RAM and FSM stay in the top module.

Test Plan:
- Load: start, bytes 20 38 E7 00, end.
  - Expect o_words=1 and RAM[0]=32'h00E73820.
  - PC=0 with i_enable=1 -> o_Instruction=32'h00E73820 one cycle later.
- Stall: load 3 words, fetch PC=4, then i_enable=0 for 3 cycles while PC=8 -> o_Instruction holds word1. Raise i_enable -> word2.
- Unloaded and out-of-range fetch:
  - Load 2 words; PC=8 -> NOP.
  - PC=4*DEPTH -> NOP.
  - PC=6 -> word1 with o_misaligned=1.
- Overflow: DEPTH=4, send 20 bytes -> o_words=4 and o_overflow=1. After end, PC=12 returns word3.
- Restart and reset:
  - i_load_start after 2 bytes -> byte_cnt=0. The next 4 bytes form RAM[0].
  - Assert i_reset mid-load -> IDLE, all outputs at reset values, fetch=NOP.
- Halt (macro defined): bytes FF FF FF FF after 1 word -> READY with o_words=2, no i_load_end needed. With the macro undefined, the block stays in LOAD.
